// File: rtl/fpu_issue_seq.sv
// Decode-to-FPU issue sequencer: runs sign-injection/min/max locally, hands arithmetic
// ops to an external core over req/ack. Optional watchdog enabled by FPU_TIMEOUT_EN.
module fpu_issue_seq #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StartF,
   input  logic [3:0]  fp_operation,
   input  logic [4:0]  fp_rd,
   input  logic [31:0] fp_rs1_data,
   input  logic [31:0] fp_rs2_data,
   output logic        fpu_busy,
   output logic        arith_req,
   output logic [2:0]  arith_op,
   output logic [31:0] arith_a,
   output logic [31:0] arith_b,
   input  logic        arith_ack,
   input  logic [31:0] arith_result,
   output logic        fp_we_w,
   output logic [4:0]  fp_waddr_w,
   output logic [31:0] fp_wdata_w,
   output logic        fp_illegal,
   output logic        fp_timeout
);

   localparam logic [31:0] QNAN = 32'h7FC00000;

   if (CNT_W != $clog2(TIMEOUT_CYCLES) + 1) begin : g_bad_cnt_w
      $error("CNT_W is derived from TIMEOUT_CYCLES and must not be overridden");
   end

   typedef enum logic {
      IDLE,
      REQ
   } state_t;

   state_t      state_q, state_d;
   logic        arith_req_q, arith_req_d;
   logic [2:0]  arith_op_q, arith_op_d;
   logic [31:0] arith_a_q, arith_a_d;
   logic [31:0] arith_b_q, arith_b_d;
   logic [4:0]  rd_q, rd_d;
   logic        fp_we_q, fp_we_d;
   logic [4:0]  fp_waddr_q, fp_waddr_d;
   logic [31:0] fp_wdata_q, fp_wdata_d;
   logic        fp_illegal_q, fp_illegal_d;
`ifdef FPU_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fp_timeout_q, fp_timeout_d;
`endif

   function automatic logic is_nan(input logic [31:0] x);
      return (&x[30:23]) && (|x[22:0]);
   endfunction

   // Sign-magnitude ordering; differing signs resolve -0 below +0.
   function automatic logic less_than(input logic [31:0] a, input logic [31:0] b);
      logic lt;
      if (a[31] != b[31])
         lt = a[31];
      else if (a[31] == 1'b0)
         lt = (a[30:0] < b[30:0]);
      else
         lt = (a[30:0] > b[30:0]);
      return lt;
   endfunction

   function automatic logic [31:0] local_result(input logic [3:0]  op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
      logic [31:0] r;
      logic        a_nan, b_nan, a_lt_b;
      a_nan  = is_nan(a);
      b_nan  = is_nan(b);
      a_lt_b = less_than(a, b);
      case (op)
         4'd5:    r = {b[31], a[30:0]};
         4'd6:    r = {~b[31], a[30:0]};
         4'd7:    r = {a[31] ^ b[31], a[30:0]};
         4'd8, 4'd9: begin
            if (a_nan && b_nan)
               r = QNAN;
            else if (a_nan)
               r = b;
            else if (b_nan)
               r = a;
            else if (op == 4'd8)
               r = a_lt_b ? a : b;
            else
               r = a_lt_b ? b : a;
         end
         default: r = a;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d      = state_q;
      arith_req_d  = arith_req_q;
      arith_op_d   = arith_op_q;
      arith_a_d    = arith_a_q;
      arith_b_d    = arith_b_q;
      rd_d         = rd_q;
      fp_we_d      = 1'b0;
      fp_waddr_d   = fp_waddr_q;
      fp_wdata_d   = fp_wdata_q;
      fp_illegal_d = 1'b0;
      fpu_busy     = 1'b0;
`ifdef FPU_TIMEOUT_EN
      cnt_d        = cnt_q;
      fp_timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (StartF) begin
               if (fp_operation <= 4'd4) begin
                  fpu_busy    = 1'b1;
                  arith_req_d = 1'b1;
                  arith_op_d  = fp_operation[2:0];
                  arith_a_d   = fp_rs1_data;
                  arith_b_d   = fp_rs2_data;
                  rd_d        = fp_rd;
                  state_d     = REQ;
`ifdef FPU_TIMEOUT_EN
                  cnt_d       = '0;
`endif
               end else if (fp_operation <= 4'd9) begin
                  fp_we_d    = 1'b1;
                  fp_waddr_d = fp_rd;
                  fp_wdata_d = local_result(fp_operation, fp_rs1_data, fp_rs2_data);
               end else begin
                  fp_illegal_d = 1'b1;
               end
            end
         end
         REQ: begin
            fpu_busy = 1'b1;
            if (arith_ack) begin
               fpu_busy    = 1'b0;
               arith_req_d = 1'b0;
               fp_we_d     = 1'b1;
               fp_waddr_d  = rd_q;
               fp_wdata_d  = arith_result;
               state_d     = IDLE;
            end
`ifdef FPU_TIMEOUT_EN
            // The current cycle is REQ cycle cnt_q+1; expire on the last allowed one.
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               fpu_busy     = 1'b0;
               arith_req_d  = 1'b0;
               fp_we_d      = 1'b1;
               fp_waddr_d   = rd_q;
               fp_wdata_d   = QNAN;
               fp_timeout_d = 1'b1;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         arith_req_q  <= 1'b0;
         arith_op_q   <= '0;
         arith_a_q    <= '0;
         arith_b_q    <= '0;
         rd_q         <= '0;
         fp_we_q      <= 1'b0;
         fp_waddr_q   <= '0;
         fp_wdata_q   <= '0;
         fp_illegal_q <= 1'b0;
`ifdef FPU_TIMEOUT_EN
         cnt_q        <= '0;
         fp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         arith_req_q  <= arith_req_d;
         arith_op_q   <= arith_op_d;
         arith_a_q    <= arith_a_d;
         arith_b_q    <= arith_b_d;
         rd_q         <= rd_d;
         fp_we_q      <= fp_we_d;
         fp_waddr_q   <= fp_waddr_d;
         fp_wdata_q   <= fp_wdata_d;
         fp_illegal_q <= fp_illegal_d;
`ifdef FPU_TIMEOUT_EN
         cnt_q        <= cnt_d;
         fp_timeout_q <= fp_timeout_d;
`endif
      end
   end

   assign arith_req  = arith_req_q;
   assign arith_op   = arith_op_q;
   assign arith_a    = arith_a_q;
   assign arith_b    = arith_b_q;
   assign fp_we_w    = fp_we_q;
   assign fp_waddr_w = fp_waddr_q;
   assign fp_wdata_w = fp_wdata_q;
   assign fp_illegal = fp_illegal_q;
`ifdef FPU_TIMEOUT_EN
   assign fp_timeout = fp_timeout_q;
`else
   assign fp_timeout = 1'b0;
`endif

endmodule
